// File: rtl/alu_tag_pool_pkg.sv
// ---------------------------------------------------------------------------
// alu_tag_pool_pkg
//   Shared sizing for the ALU reservation-station tag pool.
//   The rsSize / TagRootBus / NoFreeTag defines are the shared machine-wide
//   names (guarded so a common defines file may already have provided them).
//   The package re-exports them as typed localparams and provides a helper
//   that counts allocated (zero) bits in a free mask.
// ---------------------------------------------------------------------------
`ifndef ALU_TAG_POOL_SHARED_DEFINES
`define ALU_TAG_POOL_SHARED_DEFINES
`ifndef rsSize
`define rsSize 6
`endif
`ifndef TagRootBus
`define TagRootBus 3
`endif
`ifndef NoFreeTag
`define NoFreeTag 3'b111
`endif
`endif

package alu_tag_pool_pkg;

    localparam int RS_SIZE = `rsSize;
    localparam int TAG_W   = `TagRootBus;
    localparam logic [TAG_W-1:0] NO_FREE_TAG = `NoFreeTag;

    // Number of allocated tags = number of zero bits in the free mask.
    function automatic logic [TAG_W-1:0] count_busy(input logic [RS_SIZE-1:0] mask);
        logic [TAG_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!mask[i]) cnt = cnt + 1'b1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/alu_tag_pool.sv
// ---------------------------------------------------------------------------
// alu_tag_pool
//   Free-list of ALU reservation-station tags. The lowest-free lookup lives
//   outside this block: free_status drives an external table, which returns
//   free_tag (NO_FREE_TAG when nothing is free).
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   free_status  registered mask, bit i = 1 means tag i is free
//   free_tag     lowest free tag from the external lookup table
//   alloc_req    dispatch wants one tag this cycle
//   alloc_gnt    combinational grant
//   alloc_tag    combinational granted tag (meaningful only with alloc_gnt)
//   rel_valid    CDB broadcast releases rel_tag
//   rel_tag      tag being released
//   flush        mispredict: free every tag, no grant this cycle
//   busy_cnt     registered number of allocated tags
//   full         registered, busy_cnt == RS_SIZE
//   err_dbl_rel  sticky: release of a free tag or an out-of-range tag
//
// Configuration
//   TAG_POOL_BYPASS_EN  when defined, a full pool hands a legally released
//                       tag straight to a same-cycle alloc_req.
// ---------------------------------------------------------------------------
module alu_tag_pool
    import alu_tag_pool_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    output logic [RS_SIZE-1:0] free_status,
    input  logic [TAG_W-1:0]   free_tag,
    input  logic               alloc_req,
    output logic               alloc_gnt,
    output logic [TAG_W-1:0]   alloc_tag,
    input  logic               rel_valid,
    input  logic [TAG_W-1:0]   rel_tag,
    input  logic               flush,
    output logic [TAG_W-1:0]   busy_cnt,
    output logic               full,
    output logic               err_dbl_rel
);

    logic               normal_gnt;
    logic               bypass_gnt;
    logic               rel_legal;
    logic               rel_bad;
    logic [RS_SIZE-1:0] rel_onehot;
    logic [RS_SIZE-1:0] clr_mask;
    logic [RS_SIZE-1:0] set_mask;
    logic [RS_SIZE-1:0] next_free;

    // A shift past the top bit yields zero, so out-of-range tags (>= RS_SIZE)
    // naturally fail the "currently busy" test and are flagged as illegal.
    assign rel_onehot = RS_SIZE'(1) << rel_tag;
    assign rel_legal  = rel_valid & (|(~free_status & rel_onehot));
    assign rel_bad    = rel_valid & ~rel_legal & ~flush;

    // Grant is held off during reset so nothing downstream sees a tag that
    // the pool is about to forget.
    assign normal_gnt = rst & alloc_req & (free_tag != NO_FREE_TAG) & ~flush;

`ifdef TAG_POOL_BYPASS_EN
    assign bypass_gnt = rst & alloc_req & full & rel_legal & ~flush;
`else
    assign bypass_gnt = 1'b0;
`endif

    assign alloc_gnt = normal_gnt | bypass_gnt;
    assign alloc_tag = bypass_gnt ? rel_tag : free_tag;

    // A bypassed tag goes straight from releaser to allocator, so its bit
    // stays cleared and neither mask applies.
    assign clr_mask = (normal_gnt & ~bypass_gnt) ? (RS_SIZE'(1) << free_tag) : '0;
    assign set_mask = (rel_legal  & ~bypass_gnt) ? rel_onehot : '0;

    always_comb begin
        next_free = (free_status & ~clr_mask) | set_mask;
        if (flush) next_free = '1;
    end

    // Single state register set. busy_cnt and full are derived from the same
    // next mask so they can never drift from free_status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            free_status <= '1;
            busy_cnt    <= '0;
            full        <= 1'b0;
            err_dbl_rel <= 1'b0;
        end else begin
            free_status <= next_free;
            busy_cnt    <= count_busy(next_free);
            full        <= (next_free == '0);
            if (rel_bad) err_dbl_rel <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_tag_pool.sv
// ---------------------------------------------------------------------------
// tb_alu_tag_pool
//   Scoreboard bench for alu_tag_pool. The driver plays the role of dispatch,
//   CDB and the external lowest-free table; the reference model tracks which
//   tags are held as a plain bit array and pushes the expected response for
//   every cycle into a queue that an independent monitor pops mid-cycle.
// ---------------------------------------------------------------------------
module tb_alu_tag_pool;
    import alu_tag_pool_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] free_status;
    logic [2:0] free_tag;
    logic       alloc_req;
    logic       alloc_gnt;
    logic [2:0] alloc_tag;
    logic       rel_valid;
    logic [2:0] rel_tag;
    logic       flush;
    logic [2:0] busy_cnt;
    logic       full;
    logic       err_dbl_rel;

    always #5 clk = ~clk;

    alu_tag_pool dut (
        .clk         (clk),
        .rst         (rst),
        .free_status (free_status),
        .free_tag    (free_tag),
        .alloc_req   (alloc_req),
        .alloc_gnt   (alloc_gnt),
        .alloc_tag   (alloc_tag),
        .rel_valid   (rel_valid),
        .rel_tag     (rel_tag),
        .flush       (flush),
        .busy_cnt    (busy_cnt),
        .full        (full),
        .err_dbl_rel (err_dbl_rel)
    );

    typedef struct packed {
        logic       gnt;
        logic [2:0] tag;
        logic [5:0] fs;
        logic [2:0] cnt;
        logic       full;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: which tags are held, plus the sticky error flag.
    bit m_busy[6];
    bit m_err;

    function automatic int m_low_free();
        for (int i = 0; i < 6; i++) if (!m_busy[i]) return i;
        return 7;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 6; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [5:0] m_mask();
        logic [5:0] m;
        for (int i = 0; i < 6; i++) m[i] = !m_busy[i];
        return m;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 6; i++) m_busy[i] = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus, entered and left at posedge+1. The external
    // table is emulated from the DUT's own free_status, as in the real core.
    task automatic applyStimulus(input bit req, input bit rv, input logic [2:0] rt, input bit fl);
        exp_t       e;
        logic [2:0] ft;
        int         low;
        bit         legal;
        bit         byp;
        ft = 3'b111;
        for (int i = 5; i >= 0; i--) if (free_status[i]) ft = 3'(i);
        free_tag  = ft;
        alloc_req = req;
        rel_valid = rv;
        rel_tag   = rt;
        flush     = fl;

        low   = m_low_free();
        legal = rv && (rt < 3'd6) && m_busy[rt];
        byp   = 1'b0;
`ifdef TAG_POOL_BYPASS_EN
        byp = req && (low == 7) && legal && !fl;
`endif
        e.gnt  = byp || (req && (low != 7) && !fl);
        e.tag  = byp ? rt : 3'(low);
        e.fs   = m_mask();
        e.cnt  = 3'(m_count());
        e.full = (m_count() == 6);
        e.err  = m_err;
        sb_q.push_back(e);

        if (fl) begin
            for (int i = 0; i < 6; i++) m_busy[i] = 1'b0;
        end else begin
            if (rv && !legal) m_err = 1'b1;
            if (!byp) begin
                if (e.gnt) m_busy[low] = 1'b1;
                if (legal) m_busy[rt] = 1'b0;
            end
        end

        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic doReset();
        @(negedge clk);
        #1;
        alloc_req = 1'b1;
        free_tag  = 3'd0;
        rel_valid = 1'b0;
        flush     = 1'b0;
        rst       = 1'b0;
        #1;
        checkOutput("rst_free_status", free_status, 6'h3f);
        checkOutput("rst_busy_cnt", busy_cnt, 0);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_err", err_dbl_rel, 0);
        checkOutput("rst_gnt_blocked", alloc_gnt, 0);
        m_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        alloc_req = 1'b0;
    endtask

    // Monitor: compares whatever the driver predicted for this cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checkOutput("alloc_gnt", alloc_gnt, mon_e.gnt);
            if (mon_e.gnt) checkOutput("alloc_tag", alloc_tag, mon_e.tag);
            checkOutput("free_status", free_status, mon_e.fs);
            checkOutput("busy_cnt", busy_cnt, mon_e.cnt);
            checkOutput("full", full, mon_e.full);
            checkOutput("err_dbl_rel", err_dbl_rel, mon_e.err);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busy_list[$];
        bit r_req;
        bit r_rv;
        bit r_fl;
        logic [2:0] r_rt;

        rst       = 1'b0;
        alloc_req = 1'b0;
        rel_valid = 1'b0;
        rel_tag   = 3'd0;
        flush     = 1'b0;
        free_tag  = 3'd0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        alloc_req = 1'b1;
        #1;
        checkOutput("init_free_status", free_status, 6'h3f);
        checkOutput("init_busy_cnt", busy_cnt, 0);
        checkOutput("init_full", full, 0);
        checkOutput("init_err", err_dbl_rel, 0);
        checkOutput("init_gnt_blocked", alloc_gnt, 0);
        alloc_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Six back-to-back allocations fill the pool; the seventh is refused.
        repeat (7) applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("fill_full", full, 1);
        checkOutput("fill_busy_cnt", busy_cnt, 6);

        // Release tag 3 from full, then request again.
        applyStimulus(1'b1, 1'b1, 3'd3, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("reuse_full", full, 1);

        // Tags 0-2 busy, allocate while releasing tag 1.
        doReset();
        repeat (3) applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'd1, 1'b0);
        checkOutput("swap_free_status", free_status, 6'b110010);
        checkOutput("swap_busy_cnt", busy_cnt, 3);

        // Double release of a free tag, then an out-of-range tag.
        applyStimulus(1'b0, 1'b1, 3'd4, 1'b0);
        checkOutput("dbl_rel_err", err_dbl_rel, 1);
        checkOutput("dbl_rel_mask", free_status, 6'b110010);
        doReset();
        applyStimulus(1'b0, 1'b1, 3'd7, 1'b0);
        checkOutput("oor_rel_err", err_dbl_rel, 1);
        checkOutput("oor_rel_mask", free_status, 6'h3f);

        // Flush with concurrent request and release.
        doReset();
        repeat (4) applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'd2, 1'b1);
        checkOutput("flush_free_status", free_status, 6'h3f);
        checkOutput("flush_busy_cnt", busy_cnt, 0);
        checkOutput("flush_err", err_dbl_rel, 0);

        // Randomized traffic, mostly legal releases.
        doReset();
        repeat (400) begin
            busy_list.delete();
            for (int i = 0; i < 6; i++) if (m_busy[i]) busy_list.push_back(i);
            r_req = ($urandom_range(9) < 6);
            r_rv  = ($urandom_range(9) < 4);
            r_fl  = ($urandom_range(99) < 3);
            r_rt  = 3'($urandom_range(7));
            if (r_rv && $urandom_range(19) != 0) begin
                if (busy_list.size() > 0)
                    r_rt = 3'(busy_list[$urandom_range(busy_list.size() - 1)]);
                else
                    r_rv = 1'b0;
            end
            applyStimulus(r_req, r_rv, r_rt, r_fl);
        end

        // Asynchronous reset with five tags held.
        doReset();
        repeat (5) applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("pre_reset_busy_cnt", busy_cnt, 5);
        doReset();

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_tag_pool.md
ALU_TAG_POOL -- requirements
Module: alu_tag_pool

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; asserting low clears state immediately, release is synchronous to clk.
REQ-003 free_status  output  `rsSize (6)  registered bitmask, bit i=1 means ALU RS tag i free; drives the free-tag lookup table.
REQ-004 free_tag  input  `TagRootBus (3)  lowest free tag returned by lookup table for free_status; `NoFreeTag when mask is zero.
REQ-005 alloc_req  input  1  dispatch requests one ALU RS tag this cycle.
REQ-006 alloc_gnt  output  1  combinational; request granted this cycle.
REQ-007 alloc_tag  output  3  combinational; tag granted (valid only with alloc_gnt).
REQ-008 rel_valid  input  1  CDB broadcast retires an ALU RS entry.
REQ-009 rel_tag  input  3  tag being released.
REQ-010 flush  input  1  branch mispredict; frees all tags.
REQ-011 busy_cnt  output  3  registered count of allocated tags, 0..6.
REQ-012 full  output  1  registered; busy_cnt==6.
REQ-013 err_dbl_rel  output  1  sticky; release of an already-free tag or tag index >=6.

Function
REQ-014 alloc_gnt = alloc_req & (free_tag != `NoFreeTag) & ~flush; alloc_tag = free_tag.
REQ-015 On rising edge with alloc_gnt, bit alloc_tag of free_status cleared; busy_cnt +1.
REQ-016 On rising edge with rel_valid and legal busy rel_tag, bit rel_tag set; busy_cnt -1.
REQ-017 Alloc and release in same cycle on different tags: both applied, busy_cnt unchanged.
REQ-018 Release of a free tag or rel_tag>=6: no state change, err_dbl_rel set next edge, held until reset.
REQ-019 flush: next edge free_status=6'b111111, busy_cnt=0, no grant that cycle, any same-cycle release ignored; err_dbl_rel unchanged.
REQ-020 Full (free_status==0): alloc_gnt=0 regardless of alloc_req (without bypass, see REQ-025).
REQ-021 Grant latency zero cycles; a tag freed at edge N is grantable from cycle N onward (one-cycle release-to-reuse without bypass).
REQ-022 Invariant: busy_cnt equals number of zero bits in free_status at all times; full derived from same update.

Reset
REQ-023 rst low: free_status=6'b111111, busy_cnt=0, full=0, err_dbl_rel=0; alloc_gnt=0 while rst low.
REQ-024 Reset mid-operation discards all allocations; no pending release is remembered.

Configuration
REQ-025 TAG_POOL_BYPASS_EN defined: when full and rel_valid with legal rel_tag, alloc_req is granted rel_tag the same cycle, bit stays cleared, busy_cnt unchanged.
REQ-026 TAG_POOL_BYPASS_EN undefined: no bypass; full blocks grants until the edge after a release.

Structure
REQ-027 `rsSize, `TagRootBus, `NoFreeTag (3'b111) and tag width live in shared defines.v; no local redefinition.
REQ-028 Lowest-free lookup is external (Table); no sub-module inside; single flat module with one state register set.

Verification
REQ-029 Reset then 6 back-to-back alloc_req -> alloc_tag 0,1,2,3,4,5; full=1, busy_cnt=6; 7th request alloc_gnt=0.
REQ-030 Full, release tag 3 -> next cycle alloc_tag=3, alloc_gnt=1; with TAG_POOL_BYPASS_EN grant of 3 in release cycle.
REQ-031 Tags 0-2 busy, alloc_req with rel_tag=1 same cycle -> grant 3, then free_status=6'b110010, busy_cnt=3.
REQ-032 Release tag 4 while free -> err_dbl_rel=1 next cycle, free_status unchanged; rel_tag=7 same result.
REQ-033 4 tags busy, flush with alloc_req and rel_valid -> alloc_gnt=0, next cycle free_status=6'b111111, busy_cnt=0.
REQ-034 rst driven low asynchronously between edges with 5 busy -> outputs at reset values before next clk edge.
